// File: rtl/op_scheduler_pkg.sv
// Shared types and constants for the frame-aligned operation scheduler.
package op_scheduler_pkg;

    localparam int unsigned CMD_W   = 8;
    localparam int unsigned COORD_W = 12;
    localparam int unsigned PARAM_W = 8;
    localparam int unsigned LEN_W   = 8;

    localparam logic [CMD_W-1:0] OP_CMD_FLUSH = 8'h00;

    typedef struct packed {
        logic [COORD_W-1:0] left;
        logic [COORD_W-1:0] right;
        logic [COORD_W-1:0] top;
        logic [COORD_W-1:0] bottom;
    } op_rect_t;

    // Command plus rectangle: the part of an entry that identifies it for coalescing
    typedef struct packed {
        logic [CMD_W-1:0] cmd;
        op_rect_t         rect;
    } op_key_t;

    typedef struct packed {
        op_key_t            key;
        logic [PARAM_W-1:0] param;
        logic [LEN_W-1:0]   length;
    } op_entry_t;

    localparam int unsigned ENTRY_W = $bits(op_entry_t);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    function automatic logic rect_valid(input op_rect_t r);
        return (r.left <= r.right) && (r.top <= r.bottom);
    endfunction

    // A zero length still runs one frame
    function automatic logic [LEN_W-1:0] frames_of(input logic [LEN_W-1:0] len);
        return (len == '0) ? LEN_W'(1) : len;
    endfunction

endpackage

// File: rtl/op_scheduler_if.sv
// CSR enqueue, frame timing and active-op/status bus of the operation scheduler.
interface op_scheduler_if;
    import op_scheduler_pkg::*;

    logic               csr_en;
    logic               csr_op_en;
    logic [CMD_W-1:0]   csr_op_cmd;
    logic [COORD_W-1:0] csr_op_left;
    logic [COORD_W-1:0] csr_op_right;
    logic [COORD_W-1:0] csr_op_top;
    logic [COORD_W-1:0] csr_op_bottom;
    logic [PARAM_W-1:0] csr_op_param;
    logic [LEN_W-1:0]   csr_op_length;
    logic               frame_start;

    logic [CMD_W-1:0]   act_cmd;
    logic [COORD_W-1:0] act_left;
    logic [COORD_W-1:0] act_right;
    logic [COORD_W-1:0] act_top;
    logic [COORD_W-1:0] act_bottom;
    logic [PARAM_W-1:0] act_param;
    logic               act_frame;
    logic [LEN_W-1:0]   act_frame_idx;
    logic               act_retire;
    logic               op_busy;
    logic               op_queue;
    logic               op_full;
    logic               op_overflow;

    modport master (
        output csr_en, csr_op_en, csr_op_cmd, csr_op_left, csr_op_right, csr_op_top,
               csr_op_bottom, csr_op_param, csr_op_length, frame_start,
        input  act_cmd, act_left, act_right, act_top, act_bottom, act_param, act_frame,
               act_frame_idx, act_retire, op_busy, op_queue, op_full, op_overflow
    );

    modport slave (
        input  csr_en, csr_op_en, csr_op_cmd, csr_op_left, csr_op_right, csr_op_top,
               csr_op_bottom, csr_op_param, csr_op_length, frame_start,
        output act_cmd, act_left, act_right, act_top, act_bottom, act_param, act_frame,
               act_frame_idx, act_retire, op_busy, op_queue, op_full, op_overflow
    );

endinterface

// File: rtl/op_fifo.sv
// Pending-operation FIFO with a tail key read and tail param/length overwrite port.
module op_fifo
    import op_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    push,
    input  op_entry_t               push_data,
    input  logic                    pop,
    output op_entry_t               head_c,
    input  logic                    tail_wr,
    input  logic [PARAM_W-1:0]      tail_param,
    input  logic [LEN_W-1:0]        tail_length,
    output op_key_t                 tail_key_c,
    output logic [$clog2(DEPTH):0]  count_c,
    output logic                    full,
    output logic                    not_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    op_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_q, rd_q, wr_d, rd_d;
    logic [AW-1:0]     tail_idx;

    assign tail_idx   = AW'(wr_q - PW'(1));
    assign head_c     = mem[rd_q[AW-1:0]];
    assign tail_key_c = mem[tail_idx].key;
    assign count_c    = wr_q - rd_q;

    // Next pointers; a clear resets both so full/empty track in one cycle
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (clear) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push) wr_d = wr_q + PW'(1);
            if (pop)  rd_d = rd_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q      <= '0;
            rd_q      <= '0;
            full      <= 1'b0;
            not_empty <= 1'b0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            full      <= (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
            not_empty <= (wr_d != rd_d);
        end
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            if (push) mem[wr_q[AW-1:0]] <= push_data;
            if (tail_wr) begin
                mem[tail_idx].param  <= tail_param;
                mem[tail_idx].length <= tail_length;
            end
        end
    end

endmodule

// File: rtl/op_scheduler.sv
// Frame-aligned operation scheduler: queues CSR ops and runs them one at a time.
// Build option: define OP_SCHED_COALESCE_EN to merge repeat enqueues into the tail entry.
module op_scheduler
    import op_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    op_scheduler_if.slave bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
`ifdef OP_SCHED_COALESCE_EN
    localparam bit COALESCE = 1'b1;
`else
    localparam bit COALESCE = 1'b0;
`endif

    state_e             state_q, state_d;
    logic               flush, frame, dispatch, retire, step;
    logic               fifo_clear, fifo_push, fifo_pop, fifo_tail_wr;
    logic               fifo_full, fifo_not_empty;
    logic [CW-1:0]      fifo_count_c;
    op_entry_t          enq_entry, head_c;
    op_key_t            tail_key_c;
    logic               coalesce_hit;

    op_key_t            act_key_q, act_key_d;
    logic [PARAM_W-1:0] act_param_q, act_param_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic               act_frame_q, act_frame_d;
    logic               act_retire_q, act_retire_d;
    logic               op_busy_q, op_busy_d;
    logic               overflow_q, overflow_d;

    assign enq_entry = {bus.csr_op_cmd, bus.csr_op_left, bus.csr_op_right, bus.csr_op_top,
                        bus.csr_op_bottom, bus.csr_op_param, bus.csr_op_length};
    assign flush     = bus.csr_op_en && (bus.csr_op_cmd == OP_CMD_FLUSH);
    assign frame     = bus.frame_start && bus.csr_en;

    // The tail cannot absorb an update in the same cycle it is popped for dispatch
    assign coalesce_hit = COALESCE && fifo_not_empty && (tail_key_c == enq_entry.key)
                          && !(fifo_pop && (fifo_count_c == CW'(1)));

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state and dispatch/retire decisions
    always_comb begin
        state_d  = state_q;
        dispatch = 1'b0;
        retire   = 1'b0;
        step     = 1'b0;
        if (!bus.csr_en) begin
            retire  = (state_q == ST_ACTIVE);
            state_d = ST_IDLE;
        end else if (frame) begin
            case (state_q)
                ST_IDLE: begin
                    if (fifo_not_empty && !flush) begin
                        dispatch = 1'b1;
                        state_d  = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (remaining_q == LEN_W'(1)) begin
                        retire = 1'b1;
                        if (fifo_not_empty && !flush) dispatch = 1'b1;
                        else                          state_d  = ST_IDLE;
                    end else begin
                        step = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Next values of the registered active-op and status outputs
    always_comb begin
        act_key_d    = act_key_q;
        act_param_d  = act_param_q;
        remaining_d  = remaining_q;
        idx_d        = idx_q;
        act_frame_d  = 1'b0;
        act_retire_d = retire;
        op_busy_d    = (state_d == ST_ACTIVE);
        if (dispatch) begin
            act_key_d   = head_c.key;
            act_param_d = head_c.param;
            remaining_d = frames_of(head_c.length);
            idx_d       = '0;
            act_frame_d = 1'b1;
        end else if (step) begin
            remaining_d = remaining_q - LEN_W'(1);
            idx_d       = idx_q + LEN_W'(1);
            act_frame_d = 1'b1;
        end
    end

    // Enqueue acceptance, flush and overflow tracking
    always_comb begin
        fifo_clear   = flush || !bus.csr_en;
        fifo_pop     = dispatch;
        fifo_push    = 1'b0;
        fifo_tail_wr = 1'b0;
        overflow_d   = overflow_q;
        if (flush) begin
            overflow_d = 1'b0;
        end else if (bus.csr_en && bus.csr_op_en) begin
            if (!rect_valid(enq_entry.key.rect))  overflow_d   = 1'b1;
            else if (coalesce_hit)                fifo_tail_wr = 1'b1;
            else if (!fifo_full || fifo_pop)      fifo_push    = 1'b1;
            else                                  overflow_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_key_q    <= '0;
            act_param_q  <= '0;
            remaining_q  <= '0;
            idx_q        <= '0;
            act_frame_q  <= 1'b0;
            act_retire_q <= 1'b0;
            op_busy_q    <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            act_key_q    <= act_key_d;
            act_param_q  <= act_param_d;
            remaining_q  <= remaining_d;
            idx_q        <= idx_d;
            act_frame_q  <= act_frame_d;
            act_retire_q <= act_retire_d;
            op_busy_q    <= op_busy_d;
            overflow_q   <= overflow_d;
        end
    end

    op_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (fifo_clear),
        .push        (fifo_push),
        .push_data   (enq_entry),
        .pop         (fifo_pop),
        .head_c      (head_c),
        .tail_wr     (fifo_tail_wr),
        .tail_param  (bus.csr_op_param),
        .tail_length (bus.csr_op_length),
        .tail_key_c  (tail_key_c),
        .count_c     (fifo_count_c),
        .full        (fifo_full),
        .not_empty   (fifo_not_empty)
    );

    assign bus.act_cmd       = act_key_q.cmd;
    assign bus.act_left      = act_key_q.rect.left;
    assign bus.act_right     = act_key_q.rect.right;
    assign bus.act_top       = act_key_q.rect.top;
    assign bus.act_bottom    = act_key_q.rect.bottom;
    assign bus.act_param     = act_param_q;
    assign bus.act_frame     = act_frame_q;
    assign bus.act_frame_idx = idx_q;
    assign bus.act_retire    = act_retire_q;
    assign bus.op_busy       = op_busy_q;
    assign bus.op_queue      = fifo_not_empty;
    assign bus.op_full       = fifo_full;
    assign bus.op_overflow   = overflow_q;

endmodule
